// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch unit memory, decode and branch-feedback signal bundle
interface fetch_unit_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  imem_req;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic                  imem_ack;
    logic [23:0]           imem_data;
    logic [23:0]           code;
    logic                  code_valid;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] pc_next;
    logic                  exec_done;
    logic                  branch_taken;
    logic [ADDR_WIDTH-1:0] branch_target;

    modport master (
        output imem_req, imem_addr, code, code_valid, pc, pc_next,
        input  imem_ack, imem_data, exec_done, branch_taken, branch_target
    );

    modport slave (
        input  imem_req, imem_addr, code, code_valid, pc, pc_next,
        output imem_ack, imem_data, exec_done, branch_taken, branch_target
    );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - program counter and instruction register ahead of the control unit
module fetch_unit #(
    parameter int                    ADDR_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_unit_if.master  bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

    logic [1:0]            state_q,      state_d;
    logic [ADDR_WIDTH-1:0] fetch_pc_q,   fetch_pc_d;
    logic [ADDR_WIDTH-1:0] pc_q,         pc_d;
    logic [23:0]           code_q,       code_d;
    logic                  code_valid_q, code_valid_d;
    logic [ADDR_WIDTH-1:0] pc_inc;

    assign pc_inc = pc_q + ADDR_WIDTH'(1);

    always_comb begin
        state_d      = state_q;
        fetch_pc_d   = fetch_pc_q;
        pc_d         = pc_q;
        code_d       = code_q;
        code_valid_d = code_valid_q;
        case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (bus.imem_ack) begin
                    code_d       = bus.imem_data;
                    pc_d         = fetch_pc_q;
                    code_valid_d = 1'b1;
                    state_d      = S_HOLD;
                end
            end
            S_HOLD: begin
                // code is deliberately left alone; only the next ack replaces it
                if (bus.exec_done) begin
                    code_valid_d = 1'b0;
                    fetch_pc_d   = bus.branch_taken ? bus.branch_target : pc_inc;
                    state_d      = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            fetch_pc_q   <= RESET_PC;
            pc_q         <= RESET_PC;
            code_q       <= 24'h000000;
            code_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_pc_q   <= fetch_pc_d;
            pc_q         <= pc_d;
            code_q       <= code_d;
            code_valid_q <= code_valid_d;
        end
    end

    // request decoded straight from state so an async reset drops it immediately
    assign bus.imem_req   = (state_q == S_FETCH);
    assign bus.imem_addr  = fetch_pc_q;
    assign bus.code       = code_q;
    assign bus.code_valid = code_valid_q;
    assign bus.pc         = pc_q;
    assign bus.pc_next    = pc_inc;
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit with random memory and branch stimulus
module tb_fetch_unit;
    localparam int N = 50;

    typedef struct {
        logic [7:0]  addr;
        logic [23:0] code;
    } exp_t;

    logic clk;
    logic rst_n;
    fetch_unit_if #(.ADDR_WIDTH(8)) bus ();

    fetch_unit #(.ADDR_WIDTH(8), .RESET_PC(8'h00)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int captures = 0;
    int rel_cyc = 0;

    logic [23:0] mem [256];
    int          wait_c [N];
    int          hold_c [N];
    logic        taken_t [N];
    logic [7:0]  tgt_t [N];
    exp_t        exp_q [$];

    logic        auto_en = 1'b1;
    logic        mon_en = 1'b1;
    logic        mem_ack = 1'b0, man_ack = 1'b0;
    logic [23:0] mem_data = '0, man_data = '0;
    logic        dp_exec = 1'b0, dp_taken = 1'b0;
    logic [7:0]  dp_tgt = '0;

    assign bus.imem_ack      = auto_en ? mem_ack : man_ack;
    assign bus.imem_data     = auto_en ? mem_data : man_data;
    assign bus.exec_done     = auto_en ? dp_exec : 1'b0;
    assign bus.branch_taken  = dp_taken;
    assign bus.branch_target = dp_tgt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever @(posedge clk) cyc++;

    // memory model: per-fetch wait budget, junk ack/data while no request is open
    initial begin
        int mk = 0;
        int wcnt = 0;
        forever @(negedge clk) begin
            if (auto_en) begin
                if (bus.imem_req && mk < N) begin
                    if (wcnt >= wait_c[mk]) begin
                        mem_ack  = 1'b1;
                        mem_data = mem[bus.imem_addr];
                        mk++;
                        wcnt = 0;
                    end else begin
                        mem_ack  = 1'b0;
                        mem_data = 24'($urandom);
                        wcnt++;
                    end
                end else begin
                    mem_ack  = 1'($urandom_range(0, 1));
                    mem_data = 24'($urandom);
                end
            end
        end
    end

    // datapath model: issues branch decisions and predicts the next fetch address
    initial begin
        int dp_k = 0;
        int hcnt = 0;
        logic [7:0] model_pc = 8'h00;
        forever @(negedge clk) begin
            if (auto_en) begin
                if (bus.code_valid && dp_k < N - 1 && hcnt >= hold_c[dp_k]) begin
                    dp_exec  = 1'b1;
                    dp_taken = taken_t[dp_k];
                    dp_tgt   = tgt_t[dp_k];
                    model_pc = taken_t[dp_k] ? tgt_t[dp_k] : 8'((model_pc + 1) % 256);
                    exp_q.push_back('{addr: model_pc, code: mem[model_pc]});
                    dp_k++;
                    hcnt = 0;
                end else begin
                    dp_exec  = bus.code_valid ? 1'b0 : 1'($urandom_range(0, 1));
                    dp_taken = 1'($urandom_range(0, 1));
                    dp_tgt   = 8'($urandom);
                    if (bus.code_valid) hcnt++;
                end
            end
        end
    end

    // monitor: pops expected fetches and checks holding behaviour and timing
    initial begin
        logic        prev_valid = 1'b0;
        logic [7:0]  cur_addr = 8'h00;
        logic [23:0] cur_code = 24'h0;
        logic [23:0] last_code = 24'h0;
        int          last_cyc = 0;
        exp_t        e;
        forever @(negedge clk) begin
            if (mon_en && rst_n) begin
                if (bus.code_valid && !prev_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_capture", 32'(captures), 32'hFFFF);
                    end else begin
                        e = exp_q.pop_front();
                        cur_addr = e.addr;
                        cur_code = e.code;
                        chk("capture_code", 32'(bus.code), 32'(e.code));
                        chk("capture_pc", 32'(bus.pc), 32'(e.addr));
                        chk("capture_pc_next", 32'(bus.pc_next), 32'(8'(e.addr + 8'd1)));
                        if (captures == 0)
                            chk("first_latency", 32'(cyc - rel_cyc), 32'(2 + wait_c[0]));
                        else
                            chk("fetch_gap", 32'(cyc - last_cyc),
                                32'(2 + hold_c[captures-1] + wait_c[captures]));
                    end
                    last_code = cur_code;
                    last_cyc = cyc;
                    captures++;
                end else if (bus.code_valid) begin
                    chk("hold_code", 32'(bus.code), 32'(cur_code));
                    chk("hold_pc", 32'(bus.pc), 32'(cur_addr));
                    chk("hold_pc_next", 32'(bus.pc_next), 32'(8'(cur_addr + 8'd1)));
                    chk("hold_no_req", 32'(bus.imem_req), 32'd0);
                end else if (bus.imem_req) begin
                    if (exp_q.size() > 0) chk("fetch_addr", 32'(bus.imem_addr), 32'(exp_q[0].addr));
                    chk("fetch_code_kept", 32'(bus.code), 32'(last_code));
                end
            end
            prev_valid = bus.code_valid;
        end
    end

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = 24'h400000 ^ 24'($urandom);
        for (int k = 0; k < N; k++) begin
            wait_c[k]  = $urandom_range(0, 3);
            hold_c[k]  = $urandom_range(0, 3);
            taken_t[k] = ($urandom_range(0, 2) == 0);
            tgt_t[k]   = 8'($urandom);
        end
        // directed prefix: 0,1(3 waits),2(hold 5),3,4->20,21->FF,FF->00 wrap,00->00 self,00->01
        for (int k = 0; k < 10; k++) begin
            wait_c[k] = 0; hold_c[k] = 0; taken_t[k] = 1'b0; tgt_t[k] = 8'h00;
        end
        wait_c[1] = 3;
        hold_c[2] = 5;
        taken_t[4] = 1'b1; tgt_t[4] = 8'h20;
        taken_t[6] = 1'b1; tgt_t[6] = 8'hFF;
        taken_t[8] = 1'b1; tgt_t[8] = 8'h00;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req", 32'(bus.imem_req), 32'd0);
        chk("rst_code", 32'(bus.code), 32'h0);
        chk("rst_valid", 32'(bus.code_valid), 32'd0);
        chk("rst_pc", 32'(bus.pc), 32'h0);
        chk("rst_pc_next", 32'(bus.pc_next), 32'h1);
        exp_q.push_back('{addr: 8'h00, code: mem[0]});
        rst_n = 1'b1;
        rel_cyc = cyc;

        for (int i = 0; i < 5000 && captures < N; i++) @(negedge clk);
        chk("all_fetched", 32'(captures), 32'(N));
        repeat (4) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        // reset while holding, then while fetching with a late ack
        @(negedge clk);
        auto_en = 1'b0; mon_en = 1'b0; man_ack = 1'b0; man_data = 24'h0;
        #2 rst_n = 1'b0;
        #1;
        chk("hold_rst_req", 32'(bus.imem_req), 32'd0);
        chk("hold_rst_valid", 32'(bus.code_valid), 32'd0);
        chk("hold_rst_code", 32'(bus.code), 32'h0);
        chk("hold_rst_pc", 32'(bus.pc), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("idle_no_req", 32'(bus.imem_req), 32'd0);
        @(negedge clk);
        chk("refetch_req", 32'(bus.imem_req), 32'd1);
        chk("refetch_addr", 32'(bus.imem_addr), 32'h0);
        @(negedge clk);
        chk("wait_req", 32'(bus.imem_req), 32'd1);
        #2 rst_n = 1'b0;
        #1 chk("fetch_rst_req", 32'(bus.imem_req), 32'd0);
        @(negedge clk);
        man_ack = 1'b1; man_data = 24'hABCDEF;
        @(negedge clk);
        chk("late_ack_valid", 32'(bus.code_valid), 32'd0);
        chk("late_ack_code", 32'(bus.code), 32'h0);
        rst_n = 1'b1; man_ack = 1'b0;
        @(negedge clk);
        chk("restart_req", 32'(bus.imem_req), 32'd1);
        chk("restart_addr", 32'(bus.imem_addr), 32'h0);
        man_ack = 1'b1; man_data = mem[0];
        @(negedge clk);
        man_ack = 1'b0;
        chk("restart_valid", 32'(bus.code_valid), 32'd1);
        chk("restart_code", 32'(bus.code), 32'(mem[0]));
        chk("restart_pc", 32'(bus.pc), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
